mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single off-chip memory request/response channel between the instruction-cache refill port (read-only) and the data-cache refill/writeback port (read/write).
- Sits between the cache controllers and the top-level mem_req_*/mem_resp_* pins.
- Serializes requests with round-robin priority and locks the channel through write-data beats.
- Tags each request with the requester ID and routes responses back by tag.
- Tracks one outstanding refill per requester.

Parameters:
- MEM_ADDR_BITS, `MEM_ADDR_BITS (const.vh): request address width.
- MEM_DATA_BITS, `MEM_DATA_BITS (const.vh): data beat width.
- MEM_TAG_BITS, `MEM_TAG_BITS (const.vh): tag width; must be >= 1.
- BEATS, 4: data beats per cache line, for both reads and writes; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  icache refill request
- i_req_ready  out  1  icache request accepted (1-cycle pulse)
- i_req_addr  in  MEM_ADDR_BITS  icache line address
- i_resp_valid  out  1  icache response beat
- d_req_valid  in  1  dcache request
- d_req_ready  out  1  dcache request accepted (1-cycle pulse)
- d_req_rw  in  1  1 = write, 0 = read
- d_req_addr  in  MEM_ADDR_BITS  dcache line address
- d_wdata_valid  in  1  dcache write beat valid
- d_wdata_ready  out  1  dcache write beat accepted
- d_wdata_bits  in  MEM_DATA_BITS  write beat data
- d_wdata_mask  in  MEM_DATA_BITS/8  write beat byte mask
- d_resp_valid  out  1  dcache response beat
- resp_data  out  MEM_DATA_BITS  response data, shared by both ports
- mem_req_valid, mem_req_ready, mem_req_rw, mem_req_addr, mem_req_tag, mem_req_data_valid, mem_req_data_ready, mem_req_data_bits, mem_req_data_mask, mem_resp_valid, mem_resp_tag, mem_resp_data: memory-side channel at top-level widths, directions as at the top-level pins.

Behaviour:
- FSM states: IDLE, REQ, WDATA. Reset gives:
  - state = IDLE, last_grant = D, i_pending = d_pending = 0, beat counters = 0;
  - all valid/ready outputs = 0, mem_req_addr/tag = 0.
- Eligibility:
  - I is eligible when i_req_valid & ~i_pending.
  - D is eligible when d_req_valid & ~(d_pending & ~d_req_rw). A dcache write is allowed while its refill is pending.
- IDLE:
  - One eligible requester: it is granted.
  - Both eligible: grant goes to the requester != last_grant.
  - On grant, pulse the granted port's *_req_ready for that cycle, capture owner/rw/addr into registers, update last_grant, go to REQ.
  - The icache always sends rw = 0.
- REQ:
  - mem_req_valid = 1; mem_req_rw, mem_req_addr from registers; mem_req_tag = {0..., owner}, with I = 0 and D = 1.
  - Hold all fields stable until mem_req_ready.
  - On handshake: a read sets the owner's pending flag and clears its response counter, then goes to IDLE; a write goes to WDATA.
- WDATA:
  - Combinational pass-through: mem_req_data_valid = d_wdata_valid, d_wdata_ready = mem_req_data_ready; bits and mask are forwarded.
  - Count handshakes 0..BEATS-1; after beat BEATS-1 return to IDLE.
  - No new grant while in WDATA. The channel is locked.
- Minimum latency: request valid to mem_req_valid is 1 cycle. A granted port's next request can be accepted 2 cycles after its previous mem_req handshake, unless the pending/write rules block it.
- Responses:
  - i_resp_valid = mem_resp_valid & (mem_resp_tag[0] == 0); d_resp_valid = mem_resp_valid & (mem_resp_tag[0] == 1).
  - resp_data = mem_resp_data, with 0 added cycles.
  - Each response to a pending requester increments its counter. The BEATS-th response clears pending, and the requester is eligible again in the next cycle.
  - A response arriving for a non-pending requester is still forwarded; counters are unchanged.
- Simultaneous events:
  - A pending flag set (REQ handshake) and a final response for the same requester in one cycle cannot occur, because pending blocks a new read.
  - A response arriving during REQ or WDATA is processed normally; responses are independent of the FSM.
- Reset mid-operation: everything returns to reset values immediately and any partial write burst is abandoned.
- mem_req_data_valid = 0 outside WDATA.

Decomposition:
- Shared constants stay in const.vh: the MEM_* widths plus new `ARB_ID_I = 1'b0, `ARB_ID_D = 1'b1, `ARB_BEATS.
- FSM state encodings are localparams.
- One natural sub-module: mem_arb_resp_tracker, instantiated twice. It holds the pending flag and response-beat counter for one requester ID.

Test Plan:
- Icache-only read, addr 0x0000100, memory ready immediately:
  - mem_req_valid 1 cycle after i_req_valid, with tag 0 and rw 0.
  - 4 responses with tag 0 give 4 i_resp_valid pulses.
  - i_pending clears and a second read is granted next.
- Both I and D read requests valid in the same cycle after reset: I is granted first (last_grant = D), then D. Tags are 0, then 1.
- Dcache write, addr 0x0000200, mem_req_ready held low 3 cycles:
  - Address and tag stay stable through the stall.
  - Then exactly 4 data beats are forwarded with their masks.
  - An i_req raised during WDATA is not granted until after the 4th beat.
- Interleaved responses (tags 1, 0, 1, 0, ...) with both reads pending: each port sees exactly 4 resp_valid beats, and its pending flag clears on its own 4th beat.
- Dcache read pending, then a dcache write request: the write is granted while d_pending = 1, and a further d read is refused until 4 tag-1 responses have arrived.
- Reset asserted after 2 of 4 write beats: the next cycle shows IDLE with all outputs 0, and a fresh request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, FSM state type and tag helpers for the memory arbiter.
//   MEM_ADDR_BITS / MEM_DATA_BITS / MEM_TAG_BITS : memory channel widths
//   ARB_ID_I / ARB_ID_D                          : requester IDs carried in tag bit 0
//   ARB_BEATS                                    : data beats per cache line
package mem_arbiter_pkg;

  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_DATA_BITS = 64;
  localparam int MEM_TAG_BITS  = 4;
  localparam int ARB_BEATS     = 4;

  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2
  } arb_state_e;

  // Request tag: requester ID in bit 0, all upper bits zero.
  function automatic logic [MEM_TAG_BITS-1:0] make_tag(input logic owner);
    logic [MEM_TAG_BITS-1:0] tag;
    tag    = '0;
    tag[0] = owner;
    return tag;
  endfunction

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Off-chip memory request/response channel.
//   master : the arbiter side (drives requests and write data, receives responses)
//   slave  : the memory side
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
;

  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_req_rw;
  logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
  logic [MEM_TAG_BITS-1:0]    mem_req_tag;
  logic                       mem_req_data_valid;
  logic                       mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
  logic                       mem_resp_valid;
  logic [MEM_TAG_BITS-1:0]    mem_resp_tag;
  logic [MEM_DATA_BITS-1:0]   mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready,
    input  mem_resp_valid, mem_resp_tag, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready,
    output mem_resp_valid, mem_resp_tag, mem_resp_data
  );

endinterface

// File: rtl/mem_arb_resp_tracker.sv
// Outstanding-refill tracker for one requester.
//   set_pending : read request handed to memory (sets pending, clears count)
//   resp_beat   : a response beat tagged for this requester
//   pending     : a refill is outstanding; drops after the BEATS-th beat
module mem_arb_resp_tracker
  import mem_arbiter_pkg::*;
#(
  parameter int BEATS = ARB_BEATS
) (
  input  logic clk,
  input  logic reset,
  input  logic set_pending,
  input  logic resp_beat,
  output logic pending
);

  localparam int CNT_W = cnt_bits(BEATS);

  logic             pending_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (set_pending) begin
      pending_reg <= 1'b1;
      cnt_reg     <= '0;
    end else if (resp_beat && pending_reg) begin
      // Beats for a requester with nothing outstanding are forwarded
      // elsewhere but never counted here.
      if (cnt_reg == CNT_W'(BEATS - 1)) begin
        pending_reg <= 1'b0;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pending = pending_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request/response channel between the icache refill port
// (read-only) and the dcache refill/writeback port (read/write).
//   clk, reset            : clock, synchronous active-high reset
//   i_req_* / i_resp_valid: icache request handshake and response strobe
//   d_req_* / d_wdata_*   : dcache request handshake and write-data beats
//   d_resp_valid          : dcache response strobe
//   resp_data             : response data shared by both ports
//   mem                   : memory-side channel (master modport)
// Requests are granted round-robin, tagged with the requester ID in tag bit 0,
// and a write keeps the channel locked until all of its data beats are sent.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BEATS = ARB_BEATS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_req_valid,
  output logic                       i_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   i_req_addr,
  output logic                       i_resp_valid,
  input  logic                       d_req_valid,
  output logic                       d_req_ready,
  input  logic                       d_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   d_req_addr,
  input  logic                       d_wdata_valid,
  output logic                       d_wdata_ready,
  input  logic [MEM_DATA_BITS-1:0]   d_wdata_bits,
  input  logic [MEM_DATA_BITS/8-1:0] d_wdata_mask,
  output logic                       d_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   resp_data,
  mem_arbiter_if.master              mem
);

  localparam int BEAT_W = cnt_bits(BEATS);

  arb_state_e               state_reg, state_next;
  logic                     last_grant_reg;
  logic                     owner_reg;
  logic                     rw_reg;
  logic [MEM_ADDR_BITS-1:0] addr_reg;
  logic [BEAT_W-1:0]        beat_cnt_reg;

  logic       i_elig, d_elig;
  logic       grant, grant_id;
  logic       req_valid, data_valid, wdata_ready;
  logic       beat_fire, last_beat;
  logic [1:0] set_pending, resp_hit, pending;

  assign last_beat = (beat_cnt_reg == BEAT_W'(BEATS - 1));

  always_comb begin
    state_next  = state_reg;
    grant       = 1'b0;
    grant_id    = ARB_ID_I;
    req_valid   = 1'b0;
    data_valid  = 1'b0;
    wdata_ready = 1'b0;
    beat_fire   = 1'b0;
    set_pending = 2'b00;
    // A dcache write may go out while its own refill is still outstanding.
    i_elig = i_req_valid & ~pending[ARB_ID_I];
    d_elig = d_req_valid & ~(pending[ARB_ID_D] & ~d_req_rw);

    // Outputs stay quiet while reset is held, even before the state register
    // has taken its reset value.
    if (!reset) begin
      case (state_reg)
        ST_IDLE: begin
          if (i_elig || d_elig) begin
            grant = 1'b1;
            if (i_elig && d_elig) grant_id = ~last_grant_reg;
            else                  grant_id = i_elig ? ARB_ID_I : ARB_ID_D;
            state_next = ST_REQ;
          end
        end
        ST_REQ: begin
          req_valid = 1'b1;
          if (mem.mem_req_ready) begin
            if (rw_reg) begin
              state_next = ST_WDATA;
            end else begin
              set_pending[owner_reg] = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_WDATA: begin
          data_valid  = d_wdata_valid;
          wdata_ready = mem.mem_req_data_ready;
          beat_fire   = d_wdata_valid & mem.mem_req_data_ready;
          if (beat_fire && last_beat) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= ARB_ID_D;
      owner_reg      <= ARB_ID_I;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_reg      <= grant_id;
        last_grant_reg <= grant_id;
        rw_reg         <= (grant_id == ARB_ID_D) ? d_req_rw : 1'b0;
        addr_reg       <= (grant_id == ARB_ID_D) ? d_req_addr : i_req_addr;
      end
      if (beat_fire) beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + BEAT_W'(1);
    end
  end

  // Response routing is purely combinational and independent of the FSM.
  assign resp_hit[ARB_ID_I] = mem.mem_resp_valid & (mem.mem_resp_tag[0] == ARB_ID_I);
  assign resp_hit[ARB_ID_D] = mem.mem_resp_valid & (mem.mem_resp_tag[0] == ARB_ID_D);

  for (genvar gi = 0; gi < 2; gi++) begin : g_track
    mem_arb_resp_tracker #(.BEATS(BEATS)) u_track (
      .clk         (clk),
      .reset       (reset),
      .set_pending (set_pending[gi]),
      .resp_beat   (resp_hit[gi]),
      .pending     (pending[gi])
    );
  end

  assign i_req_ready  = grant & (grant_id == ARB_ID_I);
  assign d_req_ready  = grant & (grant_id == ARB_ID_D);
  assign i_resp_valid = resp_hit[ARB_ID_I];
  assign d_resp_valid = resp_hit[ARB_ID_D];
  assign resp_data    = mem.mem_resp_data;

  assign d_wdata_ready          = wdata_ready;
  assign mem.mem_req_valid      = req_valid;
  assign mem.mem_req_rw         = rw_reg;
  assign mem.mem_req_addr       = addr_reg;
  assign mem.mem_req_tag        = make_tag(owner_reg);
  assign mem.mem_req_data_valid = data_valid;
  assign mem.mem_req_data_bits  = d_wdata_bits;
  assign mem.mem_req_data_mask  = d_wdata_mask;

  // Only tag bit 0 selects the destination; the rest is don't-care.
  logic unused_resp_tag;
  assign unused_resp_tag = ^mem.mem_resp_tag;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic                       i_req_valid, i_req_ready, i_resp_valid;
  logic [MEM_ADDR_BITS-1:0]   i_req_addr;
  logic                       d_req_valid, d_req_ready, d_req_rw, d_resp_valid;
  logic [MEM_ADDR_BITS-1:0]   d_req_addr;
  logic                       d_wdata_valid, d_wdata_ready;
  logic [MEM_DATA_BITS-1:0]   d_wdata_bits, resp_data;
  logic [MEM_DATA_BITS/8-1:0] d_wdata_mask;

  mem_arbiter_if mem_bus();

  mem_arbiter #(.BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_rw(d_req_rw),
    .d_req_addr(d_req_addr), .d_wdata_valid(d_wdata_valid), .d_wdata_ready(d_wdata_ready),
    .d_wdata_bits(d_wdata_bits), .d_wdata_mask(d_wdata_mask), .d_resp_valid(d_resp_valid),
    .resp_data(resp_data), .mem(mem_bus)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] grant_q[$], req_q[$], beat_q[$], ir_q[$], dr_q[$];
  int resp_seq = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_req(input logic rw, input logic [MEM_ADDR_BITS-1:0] addr,
                                            input logic port);
    logic [MEM_TAG_BITS-1:0] tag;
    tag    = '0;
    tag[0] = port;
    return 128'({rw, addr, tag});
  endfunction

  // Monitor / scoreboard: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (i_req_ready || d_req_ready) begin
      check("grant_exclusive", 128'(i_req_ready & d_req_ready), 128'(0));
      if (grant_q.size() == 0) check("grant_unexpected", 128'(i_req_ready | d_req_ready), 128'(0));
      else begin
        $display("[%0t] grant %s", $time, d_req_ready ? "D" : "I");
        check("grant_port", 128'(d_req_ready), grant_q.pop_front());
      end
    end
    if (mem_bus.mem_req_valid) begin
      if (req_q.size() == 0) check("mem_req_unexpected", 128'(mem_bus.mem_req_valid), 128'(0));
      else if (mem_bus.mem_req_ready) begin
        $display("[%0t] mem_req rw=%0b addr=%0h tag=%0h", $time, mem_bus.mem_req_rw,
                 mem_bus.mem_req_addr, mem_bus.mem_req_tag);
        check("mem_req_fields", 128'({mem_bus.mem_req_rw, mem_bus.mem_req_addr, mem_bus.mem_req_tag}),
              req_q.pop_front());
      end else
        check("mem_req_stall_hold", 128'({mem_bus.mem_req_rw, mem_bus.mem_req_addr, mem_bus.mem_req_tag}),
              req_q[0]);
    end
    if (mem_bus.mem_req_data_valid) begin
      check("wdata_ready_pass", 128'(d_wdata_ready), 128'(mem_bus.mem_req_data_ready));
      if (mem_bus.mem_req_data_ready) begin
        if (beat_q.size() == 0) check("wbeat_unexpected", 128'(mem_bus.mem_req_data_valid), 128'(0));
        else begin
          $display("[%0t] wbeat data=%0h mask=%0h", $time, mem_bus.mem_req_data_bits, mem_bus.mem_req_data_mask);
          check("wbeat_fields", 128'({mem_bus.mem_req_data_bits, mem_bus.mem_req_data_mask}), beat_q.pop_front());
        end
      end
    end
    if (mem_bus.mem_resp_valid) check("resp_routed_once", 128'(i_resp_valid ^ d_resp_valid), 128'(1));
    if (i_resp_valid) begin
      if (ir_q.size() == 0) check("i_resp_unexpected", 128'(i_resp_valid), 128'(0));
      else begin
        $display("[%0t] resp I data=%0h", $time, resp_data);
        check("i_resp_data", 128'(resp_data), ir_q.pop_front());
      end
    end
    if (d_resp_valid) begin
      if (dr_q.size() == 0) check("d_resp_unexpected", 128'(d_resp_valid), 128'(0));
      else begin
        $display("[%0t] resp D data=%0h", $time, resp_data);
        check("d_resp_data", 128'(resp_data), dr_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_i_req_ready"}, 128'(i_req_ready), 128'(0));
    check({name, "_d_req_ready"}, 128'(d_req_ready), 128'(0));
    check({name, "_mem_req_valid"}, 128'(mem_bus.mem_req_valid), 128'(0));
    check({name, "_mem_data_valid"}, 128'(mem_bus.mem_req_data_valid), 128'(0));
    check({name, "_d_wdata_ready"}, 128'(d_wdata_ready), 128'(0));
    check({name, "_mem_req_addr"}, 128'(mem_bus.mem_req_addr), 128'(0));
    check({name, "_mem_req_tag"}, 128'(mem_bus.mem_req_tag), 128'(0));
    check({name, "_i_resp_valid"}, 128'(i_resp_valid), 128'(0));
    check({name, "_d_resp_valid"}, 128'(d_resp_valid), 128'(0));
  endtask

  task automatic raise(input logic port, input logic rw, input logic [MEM_ADDR_BITS-1:0] addr);
    grant_q.push_back(128'(port));
    req_q.push_back(pack_req(rw, addr, port));
    if (port == ARB_ID_D) begin
      d_req_valid = 1'b1; d_req_rw = rw; d_req_addr = addr;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
  endtask

  task automatic wait_grant(input logic port, input string name, input int exp_wait);
    int waited = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((port == ARB_ID_D) ? d_req_ready : i_req_ready) begin
        waited = c;
        break;
      end
    end
    check(name, 128'(waited), 128'(exp_wait));
    step();
    if (port == ARB_ID_D) begin d_req_valid = 1'b0; d_req_rw = 1'b0; end
    else i_req_valid = 1'b0;
  endtask

  // Memory side accepts the next request after 'stall' cycles of ready low.
  task automatic mem_accept(input int stall, input string name);
    int lat = -1;
    mem_bus.mem_req_ready = (stall == 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_bus.mem_req_valid) begin
        lat = c;
        break;
      end
    end
    check(name, 128'(lat), 128'(0));
    if (stall > 0) begin
      repeat (stall - 1) @(negedge clk);
      step();
      mem_bus.mem_req_ready = 1'b1;
      @(negedge clk);
    end
    step();
    mem_bus.mem_req_ready = 1'b0;
  endtask

  task automatic resp(input logic tag0);
    logic [MEM_DATA_BITS-1:0] data;
    resp_seq++;
    data = 64'hD0D0_0000_0000_0000 | 64'(resp_seq) | (64'(tag0) << 32);
    if (tag0) dr_q.push_back(128'(data));
    else      ir_q.push_back(128'(data));
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_tag   = {3'(resp_seq), tag0};
    mem_bus.mem_resp_data  = data;
    step();
    mem_bus.mem_resp_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] bits, input logic [7:0] mask, input bit stall);
    d_wdata_valid = 1'b1; d_wdata_bits = bits; d_wdata_mask = mask;
    if (stall) begin
      mem_bus.mem_req_data_ready = 1'b0;
      @(negedge clk);
      check("wbeat_stall_ready", 128'(d_wdata_ready), 128'(0));
      check("no_grant_in_wdata", 128'(i_req_ready), 128'(0));
      step();
    end
    mem_bus.mem_req_data_ready = 1'b1;
    beat_q.push_back(128'({bits, mask}));
    @(negedge clk);
    check("wbeat_ready", 128'(d_wdata_ready), 128'(1));
    check("no_grant_in_wdata", 128'(i_req_ready), 128'(0));
    step();
    d_wdata_valid = 1'b0;
    mem_bus.mem_req_data_ready = 1'b0;
  endtask

  task automatic blocked(input logic port, input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check(name, 128'((port == ARB_ID_D) ? d_req_ready : i_req_ready), 128'(0));
      step();
    end
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    step();
    @(negedge clk);
    check_idle(name);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_req_valid = 0; i_req_addr = '0; d_req_valid = 0; d_req_rw = 0; d_req_addr = '0;
    d_wdata_valid = 0; d_wdata_bits = '0; d_wdata_mask = '0;
    mem_bus.mem_req_ready = 0; mem_bus.mem_req_data_ready = 0;
    mem_bus.mem_resp_valid = 0; mem_bus.mem_resp_tag = '0; mem_bus.mem_resp_data = '0;
    step(); step();
    @(negedge clk); check_idle("por");
    step();
    reset = 1'b0;
    @(negedge clk); check_idle("after_reset");
    step();

    // Stray response to a non-pending requester is still forwarded.
    resp(ARB_ID_I);

    // Icache-only read, memory ready immediately; second read after the 4th beat.
    raise(ARB_ID_I, 1'b0, 28'h0000100);
    wait_grant(ARB_ID_I, "t1_grant_latency", 0);
    mem_accept(0, "t1_req_latency");
    repeat (4) resp(ARB_ID_I);
    raise(ARB_ID_I, 1'b0, 28'h0000140);
    wait_grant(ARB_ID_I, "t1_regrant_after_4", 0);
    mem_accept(0, "t1_req2_latency");
    repeat (4) resp(ARB_ID_I);

    // Simultaneous I and D reads after reset: I first, then D.
    do_reset("t2_reset");
    raise(ARB_ID_I, 1'b0, 28'h0000300);
    raise(ARB_ID_D, 1'b0, 28'h0000400);
    wait_grant(ARB_ID_I, "t2_i_first", 0);
    mem_accept(0, "t2_i_req");
    wait_grant(ARB_ID_D, "t2_d_second", 0);
    mem_accept(0, "t2_d_req");

    // Interleaved responses: D finishes on its 4th beat while I still waits.
    for (int k = 0; k < 7; k++) resp((k % 2 == 0) ? ARB_ID_D : ARB_ID_I);
    raise(ARB_ID_D, 1'b0, 28'h0000500);
    raise(ARB_ID_I, 1'b0, 28'h0000900);
    wait_grant(ARB_ID_D, "t4_d_free_after_own_4th", 0);
    mem_accept(0, "t4_d_req");
    blocked(ARB_ID_I, 3, "t4_i_blocked_pending");
    resp(ARB_ID_I);
    wait_grant(ARB_ID_I, "t4_i_free_after_own_4th", 0);
    mem_accept(0, "t4_i_req");
    repeat (4) resp(ARB_ID_I);

    // Dcache write while its read is pending, 3-cycle stall, locked channel.
    raise(ARB_ID_D, 1'b1, 28'h0000200);
    wait_grant(ARB_ID_D, "t5_write_while_pending", 0);
    mem_accept(3, "t5_wr_req");
    raise(ARB_ID_I, 1'b0, 28'h0000600);
    send_beat(64'hA5A5_0000_0000_0000, 8'hFF, 1'b0);
    send_beat(64'hA5A5_0000_0000_0001, 8'h0F, 1'b0);
    blocked(ARB_ID_I, 1, "t5_no_grant_bubble");
    send_beat(64'hA5A5_0000_0000_0002, 8'hF0, 1'b1);
    send_beat(64'hA5A5_0000_0000_0003, 8'h3C, 1'b0);
    wait_grant(ARB_ID_I, "t5_i_after_4th_beat", 0);
    mem_accept(0, "t5_i_req");

    // Further D read refused until the pending D refill completes.
    raise(ARB_ID_D, 1'b0, 28'h0000700);
    blocked(ARB_ID_D, 3, "t5_d_read_refused");
    repeat (4) resp(ARB_ID_D);
    wait_grant(ARB_ID_D, "t5_d_read_after_4", 0);
    mem_accept(0, "t5_d_rd_req");
    for (int k = 0; k < 8; k++) resp((k % 2 == 0) ? ARB_ID_I : ARB_ID_D);

    // Reset after 2 of 4 write beats abandons the burst.
    raise(ARB_ID_D, 1'b1, 28'h0000800);
    wait_grant(ARB_ID_D, "t6_wr_grant", 0);
    mem_accept(0, "t6_wr_req");
    send_beat(64'hBEEF_0000_0000_0000, 8'hFF, 1'b0);
    send_beat(64'hBEEF_0000_0000_0001, 8'hAA, 1'b0);
    reset = 1'b1;
    step();
    d_wdata_valid = 1'b1; mem_bus.mem_req_data_ready = 1'b1;
    @(negedge clk); check_idle("t6_in_reset");
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t6_no_data_valid_idle", 128'(mem_bus.mem_req_data_valid), 128'(0));
    check("t6_no_wdata_ready_idle", 128'(d_wdata_ready), 128'(0));
    step();
    d_wdata_valid = 1'b0; mem_bus.mem_req_data_ready = 1'b0;
    raise(ARB_ID_I, 1'b0, 28'h0000A00);
    wait_grant(ARB_ID_I, "t6_fresh_grant", 0);
    mem_accept(0, "t6_fresh_req");
    repeat (4) resp(ARB_ID_I);
    raise(ARB_ID_D, 1'b1, 28'h0000B00);
    wait_grant(ARB_ID_D, "t6_fresh_write", 0);
    mem_accept(0, "t6_fresh_wr_req");
    for (int b = 0; b < 4; b++) send_beat(64'hC0DE_0000_0000_0000 | 64'(b), 8'h81, 1'b0);
    @(negedge clk);
    check("t6_burst_done_idle", 128'(d_wdata_ready), 128'(0));
    step();

    check("grant_q_drained", 128'(grant_q.size()), 128'(0));
    check("req_q_drained", 128'(req_q.size()), 128'(0));
    check("beat_q_drained", 128'(beat_q.size()), 128'(0));
    check("ir_q_drained", 128'(ir_q.size()), 128'(0));
    check("dr_q_drained", 128'(dr_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
